// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC ownership, in-order imem requests, fetch buffer, redirects
// One request in flight at most; DRAIN swallows the response of a request made stale by a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        AnyStall,
   input  logic        Jump_IDM1,
   input  logic [25:0] JumpTgt_IDM1,
   input  logic        Redirect_EX,
   input  logic [31:0] RedirectPc_EX,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemGnt,
   input  logic        ImemRspVal,
   input  logic [31:0] ImemRspData,
   output logic [31:0] Pc_IF,
   output logic [31:0] FetchData_IF,
   output logic        InstrVal_IF
);
   localparam int PW = $clog2(IBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [31:0]   last_pc_q, last_pc_d;
   logic          outstanding_q, outstanding_d;
   logic [0:0]    state_q, state_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   buf_pc_q    [IBUF_DEPTH];
   logic [31:0]   buf_instr_q [IBUF_DEPTH];

   logic          valid, jump, redirect, push, pop, grant, room;
   logic [31:0]   head_pc, target;
   logic [3:0]    jump_region;
   logic [CW-1:0] fill;

   assign valid   = (count_q != '0);
   assign head_pc = buf_pc_q[rd_ptr_q];

   // Region bits come from PC+4, so carry out of bits [27:2] bumps them.
   assign jump_region = head_pc[31:28] + {3'b000, &head_pc[27:2]};
   assign jump     = Jump_IDM1 & valid & ~AnyStall & ~Redirect_EX;
   assign redirect = Redirect_EX | jump;
   assign target   = Redirect_EX ? RedirectPc_EX : {jump_region, JumpTgt_IDM1, 2'b00};

   assign push = ImemRspVal & outstanding_q & (state_q == ST_RUN) & ~redirect;
   assign pop  = valid & ~AnyStall & ~redirect;
   assign fill = count_q + {{PW{1'b0}}, push};
   assign room = (fill < CW'(IBUF_DEPTH));

   assign ImemReq  = ~reset & (state_q == ST_RUN) & ~outstanding_q & room & ~redirect;
   assign ImemAddr = fetch_pc_q;
   assign grant    = ImemReq & ImemGnt;

   assign InstrVal_IF  = valid;
   assign Pc_IF        = valid ? head_pc : last_pc_q;
   assign FetchData_IF = valid ? buf_instr_q[rd_ptr_q] : 32'h0;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      last_pc_d     = last_pc_q;
      outstanding_d = outstanding_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (redirect)   fetch_pc_d = target;
      else if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

      if (grant) begin
         req_pc_d      = fetch_pc_q;
         outstanding_d = 1'b1;
      end else if (ImemRspVal) begin
         outstanding_d = 1'b0;
      end

      // A taken jump consumes its own word, so it counts as a pop for Pc_IF history.
      if (valid & ~AnyStall & ~Redirect_EX) last_pc_d = head_pc;

      state_d = (outstanding_q & ~ImemRspVal & (redirect | (state_q == ST_DRAIN)))
                ? ST_DRAIN : ST_RUN;

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = fill - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= 32'h0;
         last_pc_q     <= 32'h0;
         outstanding_q <= 1'b0;
         state_q       <= ST_RUN;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         last_pc_q     <= last_pc_d;
         outstanding_q <= outstanding_d;
         state_q       <= state_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]    <= req_pc_q;
         buf_instr_q[wr_ptr_q] <= ImemRspData;
      end
   end
endmodule
